intf_or: RTL and testbench
==========================

# intf_or

Handshaked bit-wise OR combiner with Bluespec-style method ports: two enable/ready inputs (`a`, `b`) and one enable/ready output (`y`). Operand `a` and operand `b` are each buffered in their own input FIFO. When both FIFOs hold a value, the head values are ORed and the result is queued in an output FIFO for the consumer. It sits between two independent producers and one consumer in a flow-controlled datapath.

## Interface
Parameters:
- `W`, default 1: data width of `a`, `b` and `y`.
- `DEPTH`, default 2: entries per FIFO; applies to all three FIFOs; minimum 1.

Ports:
- `CLK`  input  1  clock; all state is on the rising edge.
- `RST_N`  input  1  reset. One clock; reset is asynchronous and active-high (asserted when `RST_N`=1).
- `a_data`  input  W  operand A.
- `a_en`  input  1  enqueue operand A this cycle.
- `a_rdy`  output  1  operand-A FIFO not full.
- `b_data`  input  W  operand B.
- `b_en`  input  1  enqueue operand B this cycle.
- `b_rdy`  output  1  operand-B FIFO not full.
- `y_en`  input  1  dequeue result this cycle.
- `y_data`  output  W  head of the result FIFO.
- `y_rdy`  output  1  result FIFO not empty.

## Operation
- Enqueue A: when `a_en && a_rdy`, `a_data` is written to the A FIFO. If `a_en` is high while `a_rdy` is low, the request is ignored and no state changes.
- Enqueue B: same rule, using `b_en`, `b_rdy`, `b_data` and the B FIFO.
- Combine: the combine step fires when all three hold: A FIFO not empty, B FIFO not empty, and result FIFO not full.
  - When it fires, both input heads are popped and `A_head | B_head` (bitwise, W bits) is pushed to the result FIFO.
- Dequeue: when `y_en && y_rdy`, the result head is popped. If `y_en` is high while `y_rdy` is low, the request is ignored.
- Ordering: results leave in strict FIFO order. The k-th result is the OR of the k-th accepted A and the k-th accepted B.
- Ready outputs: `a_rdy`, `b_rdy` and `y_rdy` are derived from registered occupancy counts only. They never depend combinationally on `*_en` inputs.
- `y_data`: equals the result-FIFO head when `y_rdy`=1, and is 0 when the result FIFO is empty.
- Reset:
  - All FIFOs are emptied.
  - While reset is asserted, `a_rdy`, `b_rdy`, `y_rdy` and `y_data` are all 0.
  - One cycle after deassertion, `a_rdy`=`b_rdy`=1 and `y_rdy`=0.
  - Asserting reset mid-stream discards all queued data immediately.

## Timing
- Input-to-output latency is 2 cycles:
  - An A/B pair accepted at edge N appears in the input FIFOs after edge N.
  - The combine fires at edge N+1.
  - `y_rdy` rises after edge N+1.
- If A and B arrive on different edges, the combine fires on the first edge after the later of the two is stored.
- Simultaneous push and pop on the same FIFO in one cycle is allowed whenever ready permits. The count is unchanged and the data stays coherent.
- There is no bypass:
  - A full result FIFO blocks the combine, even if `y_en` pops it in the same cycle.
  - A full input FIFO keeps `*_rdy` low, even if a combine pops it in the same cycle.
- Pointers wrap modulo `DEPTH`. Occupancy counts range from 0 to `DEPTH`.
- Sustained throughput is 1 result per cycle when `DEPTH`≥2 and `y_en` is held high.

## Structure
- Package `intf_or_pkg`: defaults for `W` and `DEPTH`, and the count-width helper `$clog2(DEPTH+1)`.
- Sub-module `sync_fifo` (parameters `W`, `DEPTH`):
  - Ports: `enq`, `din`, `deq`, `dout`, `full`, `empty`; async active-high clear.
  - Instantiated three times, for A, B and Y.
- Top level: the combine-fire logic, the OR gate, and gating of the ready outputs during reset.

## Test plan
- Reset: assert `RST_N`=1 for 3 cycles -> `a_rdy`=`b_rdy`=`y_rdy`=0 during reset; after release `a_rdy`=`b_rdy`=1, `y_rdy`=0, `y_data`=0.
- Truth table: enqueue pairs (0,0), (0,1), (1,0), (1,1) on the same cycles with `y_en`=1 -> `y_data` sequence 0, 1, 1, 1, the first result 2 cycles after the first pair.
- Skewed arrival: A=1 at cycle 0, B=0 at cycle 3 -> `y_rdy` stays 0 until 2 cycles after B, then `y_data`=1.
- Backpressure: `y_en`=0, feed A/B pairs continuously -> result FIFO fills with 2 entries, then both input FIFOs fill with 2 each, then `a_rdy`=`b_rdy`=0. Extra `a_en` pulses are ignored. Draining with `y_en`=1 returns exactly 4 results, in order.
- Illegal enables: `y_en`=1 while empty, and `a_en`=1 while full -> no state change, no spurious output.
- Mid-stream reset: queue 3 results, assert reset for 1 cycle -> all FIFOs empty, `y_rdy`=0, and subsequent traffic is correct from a clean state.

Source files
------------

// File: rtl/intf_or_pkg.sv
// Shared defaults and sizing helpers for the intf_or combiner and its FIFOs.
package intf_or_pkg;

    localparam int W_DEF     = 1;
    localparam int DEPTH_DEF = 2;

    // Bits needed to hold an occupancy count from 0 up to and including depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry FIFO still gets a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/intf_or_if.sv
// Enable/ready method bundle for intf_or: two operand enqueue ports and one
// result dequeue port. The slave side is the combiner; the master side is the
// producers/consumer.
interface intf_or_if
    import intf_or_pkg::*;
#(
    parameter int W = W_DEF
);

    logic [W-1:0] a_data;
    logic         a_en;
    logic         a_rdy;
    logic [W-1:0] b_data;
    logic         b_en;
    logic         b_rdy;
    logic         y_en;
    logic [W-1:0] y_data;
    logic         y_rdy;

    modport slave (
        input  a_data, a_en, b_data, b_en, y_en,
        output a_rdy, b_rdy, y_data, y_rdy
    );

    modport master (
        output a_data, a_en, b_data, b_en, y_en,
        input  a_rdy, b_rdy, y_data, y_rdy
    );

endinterface

// File: rtl/intf_or_sync_fifo.sv
// Single-clock FIFO with registered occupancy count. full/empty come from the
// count register only, so they never depend on this cycle's enq/deq.
// Over-full enqueues and empty dequeues are dropped without side effects.
module sync_fifo
    import intf_or_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         enq,
    input  logic [W-1:0] din,
    input  logic         deq,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Advance a pointer, wrapping at DEPTH (which need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign push  = enq & ~full;
    assign pop   = deq & ~empty;
    assign dout  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the FIFO at once.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until the count covers them.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/intf_or.sv
// Handshaked bitwise OR combiner. Operands A and B are queued independently;
// whenever both have a head and the result queue has room, the heads are
// popped and their OR is queued for the consumer. No bypass paths: readiness
// reflects registered occupancy only.
module intf_or
    import intf_or_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic      CLK,
    input  logic      RST_N,
    intf_or_if.slave  bus
);

    logic [W-1:0] a_head;
    logic [W-1:0] b_head;
    logic [W-1:0] y_head;
    logic [W-1:0] y_res;
    logic         a_full;
    logic         a_empty;
    logic         b_full;
    logic         b_empty;
    logic         y_full;
    logic         y_empty;
    logic         fire;

    // Combine when both operands are present and the result FIFO has room.
    always_comb begin
        fire  = ~a_empty & ~b_empty & ~y_full;
        y_res = a_head | b_head;
    end

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_a_fifo (
        .clk   (CLK),
        .clr   (RST_N),
        .enq   (bus.a_en),
        .din   (bus.a_data),
        .deq   (fire),
        .dout  (a_head),
        .full  (a_full),
        .empty (a_empty)
    );

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_b_fifo (
        .clk   (CLK),
        .clr   (RST_N),
        .enq   (bus.b_en),
        .din   (bus.b_data),
        .deq   (fire),
        .dout  (b_head),
        .full  (b_full),
        .empty (b_empty)
    );

    sync_fifo #(.W(W), .DEPTH(DEPTH)) u_y_fifo (
        .clk   (CLK),
        .clr   (RST_N),
        .enq   (fire),
        .din   (y_res),
        .deq   (bus.y_en),
        .dout  (y_head),
        .full  (y_full),
        .empty (y_empty)
    );

    // Ready/data outputs are forced low while reset is held; y_data reads 0
    // whenever there is no valid result so stale storage never leaks out.
    assign bus.a_rdy  = ~a_full & ~RST_N;
    assign bus.b_rdy  = ~b_full & ~RST_N;
    assign bus.y_rdy  = ~y_empty & ~RST_N;
    assign bus.y_data = (y_empty | RST_N) ? '0 : y_head;

endmodule

// File: tb/tb_intf_or.sv
// Bench for intf_or: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the three FIFOs.
module tb_intf_or;

    localparam int W     = 4;
    localparam int DEPTH = 2;

    typedef logic [W-1:0] dat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    intf_or_if #(.W(W)) bus ();

    intf_or #(.W(W), .DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .RST_N (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cnum  = 0;
    dat_t qa[$];
    dat_t qb[$];
    dat_t qy[$];
    dat_t got[$];
    int   gotc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare outputs with the model, advance both.
    task automatic cyc(input logic ae, input dat_t ad, input logic be, input dat_t bd,
                       input logic ye);
        bit   fire, acc_a, acc_b, popy;
        dat_t r;
        bus.a_en = ae; bus.a_data = ad;
        bus.b_en = be; bus.b_data = bd;
        bus.y_en = ye;
        #1;
        chk("a_rdy",  32'(bus.a_rdy),  32'(qa.size() < DEPTH));
        chk("b_rdy",  32'(bus.b_rdy),  32'(qb.size() < DEPTH));
        chk("y_rdy",  32'(bus.y_rdy),  32'(qy.size() > 0));
        chk("y_data", 32'(bus.y_data), 32'((qy.size() > 0) ? qy[0] : dat_t'(0)));
        if (ye && bus.y_rdy) begin
            got.push_back(bus.y_data);
            gotc.push_back(cnum);
        end
        fire  = (qa.size() > 0) && (qb.size() > 0) && (qy.size() < DEPTH);
        acc_a = ae && (qa.size() < DEPTH);
        acc_b = be && (qb.size() < DEPTH);
        popy  = ye && (qy.size() > 0);
        @(posedge clk);
        if (fire) r = qa.pop_front() | qb.pop_front();
        if (popy) void'(qy.pop_front());
        if (fire) qy.push_back(r);
        if (acc_a) qa.push_back(ad);
        if (acc_b) qb.push_back(bd);
        cnum++;
        #1;
    endtask

    task automatic idle(input logic ye);
        cyc(1'b0, '0, 1'b0, '0, ye);
    endtask

    // Assert reset asynchronously mid-cycle, hold for n edges, then release.
    task automatic do_rst(input int n);
        bus.a_en = 0; bus.b_en = 0; bus.y_en = 0;
        bus.a_data = '0; bus.b_data = '0;
        rst = 1'b1;
        #1;
        qa.delete(); qb.delete(); qy.delete();
        chk("rst_a_rdy",  32'(bus.a_rdy),  0);
        chk("rst_b_rdy",  32'(bus.b_rdy),  0);
        chk("rst_y_rdy",  32'(bus.y_rdy),  0);
        chk("rst_y_data", 32'(bus.y_data), 0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_a_rdy", 32'(bus.a_rdy), 0);
            chk("rst_hold_y_rdy", 32'(bus.y_rdy), 0);
        end
        rst = 1'b0;
        #1;
    endtask

    dat_t av[6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5};
    dat_t bv[6] = '{4'h0, 4'h8, 4'h1, 4'h6, 4'hC, 4'hA};

    initial begin
        int c0;
        bus.a_en = 0; bus.b_en = 0; bus.y_en = 0;
        bus.a_data = '0; bus.b_data = '0;
        #2;

        // Reset for 3 cycles, then one idle cycle.
        do_rst(3);
        idle(1'b0);
        chk("post_rst_a_rdy",  32'(bus.a_rdy),  1);
        chk("post_rst_b_rdy",  32'(bus.b_rdy),  1);
        chk("post_rst_y_rdy",  32'(bus.y_rdy),  0);
        chk("post_rst_y_data", 32'(bus.y_data), 0);

        // Truth table with y_en held high.
        got.delete(); gotc.delete();
        c0 = cnum;
        cyc(1, 4'h0, 1, 4'h0, 1);
        cyc(1, 4'h0, 1, 4'h1, 1);
        cyc(1, 4'h1, 1, 4'h0, 1);
        cyc(1, 4'h1, 1, 4'h1, 1);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("tt_count", 32'(got.size()), 4);
        if (got.size() == 4) begin
            chk("tt_r0", 32'(got[0]), 0);
            chk("tt_r1", 32'(got[1]), 1);
            chk("tt_r2", 32'(got[2]), 1);
            chk("tt_r3", 32'(got[3]), 1);
            chk("tt_latency", 32'(gotc[0] - c0), 2);
        end

        // Skewed arrival: A first, B three cycles later.
        cyc(1, 4'h1, 0, 4'h0, 0);
        idle(1'b0);
        chk("skew_wait1", 32'(bus.y_rdy), 0);
        idle(1'b0);
        chk("skew_wait2", 32'(bus.y_rdy), 0);
        cyc(0, 4'h0, 1, 4'h0, 0);
        chk("skew_after_b", 32'(bus.y_rdy), 0);
        idle(1'b0);
        chk("skew_rdy",  32'(bus.y_rdy),  1);
        chk("skew_data", 32'(bus.y_data), 1);
        idle(1'b1);
        idle(1'b0);

        // Backpressure: consumer stalled, producers keep pushing.
        got.delete(); gotc.delete();
        for (int i = 0; i < 6; i++) cyc(1, av[i], 1, bv[i], 0);
        chk("bp_a_rdy", 32'(bus.a_rdy), 0);
        chk("bp_b_rdy", 32'(bus.b_rdy), 0);
        chk("bp_y_rdy", 32'(bus.y_rdy), 1);
        cyc(1, 4'hF, 0, 4'h0, 0);
        cyc(1, 4'hF, 1, 4'hF, 0);
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("bp_count", 32'(got.size()), 4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("bp_order", 32'(got[i]), 32'(av[i] | bv[i]));

        // Illegal dequeue while empty.
        got.delete();
        idle(1'b1);
        idle(1'b1);
        chk("empty_deq_y_rdy", 32'(bus.y_rdy), 0);
        chk("empty_deq_none",  32'(got.size()), 0);

        // Mid-stream reset with queued results.
        for (int i = 0; i < 3; i++) cyc(1, av[i+3], 1, bv[i+3], 0);
        idle(1'b0);
        idle(1'b0);
        chk("mid_pre_y_rdy", 32'(bus.y_rdy), 1);
        do_rst(1);
        idle(1'b0);
        chk("mid_a_rdy",  32'(bus.a_rdy),  1);
        chk("mid_y_rdy",  32'(bus.y_rdy),  0);
        chk("mid_y_data", 32'(bus.y_data), 0);
        got.delete();
        cyc(1, 4'h9, 1, 4'h2, 1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("mid_after_count", 32'(got.size()), 1);
        if (got.size() == 1) chk("mid_after_data", 32'(got[0]), 32'h0B);

        // Random traffic with varying producer/consumer duty.
        for (int i = 0; i < 400; i++) begin
            int bias;
            bias = (i < 200) ? 2 : 4;
            cyc(($urandom % 4) != 0, dat_t'($urandom),
                ($urandom % 4) != 0, dat_t'($urandom),
                ($urandom % bias) != 0);
        end
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("final_empty", 32'(bus.y_rdy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
